// File: rtl/unidad_debug_recolector.sv
// unidad_debug_recolector
//   Debug controller for the MIPS pipeline. Accepts RUN/STEP/DUMP command
//   bytes from the host and gates pipeline advance. On every stop it
//   snapshots the four inter-stage latches and the enabled-cycle count. It
//   then streams a framed byte dump: header, latches, register file, data
//   memory and cycle count, with every multi-byte field sent MSB first.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd      host command byte; o_cmd_ready high while idle
//   i_halt                 CPU halt flag
//   i_if_id..i_mem_wb      pipeline latches (snapshotted)
//   i_reg_reco/i_mem_reco  register / memory read data, RD_LAT cycles late
//   o_cpu_enable           pipeline advance enable
//   o_debug_flag           steers RF / memory addressing to recolector ports
//   o_addr_*_reco          recolector read indices
//   o_tx_data/valid/ready  byte stream to the UART TX
//   o_busy                 any state except IDLE
//   o_cycle_count          saturating count of enabled cycles
module unidad_debug_recolector #(
  parameter int LEN       = 32,
  parameter int NB_IF_ID  = 96,
  parameter int NB_ID_EX  = 160,
  parameter int NB_EX_MEM = 128,
  parameter int NB_MEM_WB = 96,
  parameter int CANT_REG  = 16,
  parameter int CANT_MEM  = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cmd_valid,
  input  logic [7:0]                  i_cmd,
  output logic                        o_cmd_ready,
  input  logic                        i_halt,
  input  logic [NB_IF_ID-1:0]         i_if_id,
  input  logic [NB_ID_EX-1:0]         i_id_ex,
  input  logic [NB_EX_MEM-1:0]        i_ex_mem,
  input  logic [NB_MEM_WB-1:0]        i_mem_wb,
  input  logic [LEN-1:0]              i_reg_reco,
  input  logic [LEN-1:0]              i_mem_reco,
  output logic                        o_cpu_enable,
  output logic                        o_debug_flag,
  output logic [$clog2(CANT_REG)-1:0] o_addr_reg_reco,
  output logic [$clog2(CANT_MEM)-1:0] o_addr_memdatos_reco,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic [LEN-1:0]              o_cycle_count
);

  localparam int NB_LAT    = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int LAT_BYTES = NB_LAT / 8;
  localparam int WB        = LEN / 8;
  localparam int AWR       = $clog2(CANT_REG);
  localparam int AWM       = $clog2(CANT_MEM);
  localparam int IDXW      = $clog2(LAT_BYTES + WB) + 1;

  typedef enum logic [3:0] {
    IDLE, RUN, STEP, SNAP, HDR, LAT, RADDR, RWAIT, RSEND, CNT
  } state_t;

  state_t            state_q, state_d;
  logic [NB_LAT-1:0] lat_q, lat_d;
  logic [LEN-1:0]    cnt_snap_q, cnt_snap_d;
  logic [LEN-1:0]    word_q, word_d;
  logic [LEN-1:0]    cycle_q, cycle_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [AWR-1:0]    addr_reg_q, addr_reg_d;
  logic [AWM-1:0]    addr_mem_q, addr_mem_d;
  logic              mem_phase_q, mem_phase_d;
  logic [1:0]        wait_q, wait_d;
  logic              flag_q, flag_d;
  logic              capture;
  logic              xfer;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cnt_snap_q  <= '0;
      word_q      <= '0;
      cycle_q     <= '0;
      idx_q       <= '0;
      addr_reg_q  <= '0;
      addr_mem_q  <= '0;
      mem_phase_q <= 1'b0;
      wait_q      <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cnt_snap_q  <= cnt_snap_d;
      word_q      <= word_d;
      cycle_q     <= cycle_d;
      idx_q       <= idx_d;
      addr_reg_q  <= addr_reg_d;
      addr_mem_q  <= addr_mem_d;
      mem_phase_q <= mem_phase_d;
      wait_q      <= wait_d;
      flag_q      <= flag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    cnt_snap_d   = cnt_snap_q;
    word_d       = word_q;
    idx_d        = idx_q;
    addr_reg_d   = addr_reg_q;
    addr_mem_d   = addr_mem_q;
    mem_phase_d  = mem_phase_q;
    wait_d       = wait_q;
    flag_d       = flag_q;
    capture      = 1'b0;
    o_cpu_enable = 1'b0;
    o_tx_valid   = 1'b0;
    o_tx_data    = 8'h00;

    unique case (state_q)
      IDLE: begin
        // Unknown command bytes are consumed here and simply ignored.
        if (i_cmd_valid) begin
          case (i_cmd)
            8'h01:   state_d = i_halt ? SNAP : RUN;
            8'h02:   state_d = STEP;
            8'h03:   state_d = SNAP;
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        // Enable is gated by halt combinationally so no extra cycle slips.
        if (i_halt) state_d = SNAP;
        else        o_cpu_enable = 1'b1;
      end
      STEP: begin
        o_cpu_enable = !i_halt;
        state_d      = SNAP;
      end
      SNAP: begin
        lat_d      = {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
        cnt_snap_d = cycle_q;
        idx_d      = '0;
        state_d    = HDR;
      end
      HDR: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'hA5;
        if (i_tx_ready) state_d = LAT;
      end
      LAT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = lat_q[NB_LAT-1 -: 8];
        if (i_tx_ready) begin
          lat_d = lat_q << 8;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDXW'(LAT_BYTES - 1)) begin
            idx_d       = '0;
            addr_reg_d  = '0;
            addr_mem_d  = '0;
            mem_phase_d = 1'b0;
            flag_d      = 1'b1;
            state_d     = RADDR;
          end
        end
      end
      RADDR: begin
        // The index was registered on entry; data is valid RD_LAT cycles on.
        wait_d = '0;
        if (RD_LAT == 0) capture = 1'b1;
        else             state_d = RWAIT;
      end
      RWAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == 2'(RD_LAT - 1)) capture = 1'b1;
      end
      RSEND: begin
        o_tx_valid = 1'b1;
        o_tx_data  = word_q[LEN-1 -: 8];
        if (i_tx_ready) begin
          word_d = word_q << 8;
          idx_d  = idx_q + 1'b1;
          if (idx_q == IDXW'(WB - 1)) begin
            idx_d   = '0;
            state_d = RADDR;
            if (!mem_phase_q) begin
              if (addr_reg_q == AWR'(CANT_REG - 1)) begin
                addr_reg_d  = '0;
                mem_phase_d = 1'b1;
              end else begin
                addr_reg_d = addr_reg_q + 1'b1;
              end
            end else if (addr_mem_q == AWM'(CANT_MEM - 1)) begin
              addr_mem_d = '0;
              state_d    = CNT;
            end else begin
              addr_mem_d = addr_mem_q + 1'b1;
            end
          end
        end
      end
      CNT: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cnt_snap_q[LEN-1 -: 8];
        if (i_tx_ready) begin
          cnt_snap_d = cnt_snap_q << 8;
          idx_d      = idx_q + 1'b1;
          if (idx_q == IDXW'(WB - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared word capture for both RADDR (zero latency) and RWAIT.
    if (capture) begin
      word_d  = mem_phase_q ? i_mem_reco : i_reg_reco;
      idx_d   = '0;
      state_d = RSEND;
      if (mem_phase_q && addr_mem_q == AWM'(CANT_MEM - 1)) flag_d = 1'b0;
    end

    cycle_d = (o_cpu_enable && cycle_q != '1) ? cycle_q + 1'b1 : cycle_q;
  end

  assign xfer                 = o_tx_valid && i_tx_ready;
  assign o_cmd_ready          = (state_q == IDLE);
  assign o_busy               = (state_q != IDLE);
  assign o_debug_flag         = flag_q;
  assign o_addr_reg_reco      = addr_reg_q;
  assign o_addr_memdatos_reco = addr_mem_q;
  assign o_cycle_count        = cycle_q;

  // A byte handshake is only meaningful while a streaming state drives valid.
  property p_no_xfer_idle;
    @(posedge i_clk) disable iff (!i_rst) xfer |-> (state_q != IDLE);
  endproperty
  assert property (p_no_xfer_idle);

endmodule

// File: tb/tb_unidad_debug_recolector.sv
// tb_unidad_debug_recolector
//   Drives host commands, a halting CPU, a latency-delayed register file and
//   data memory, and a TX sink with variable ready. Expected frames are built
//   as byte queues from the frame rules and compared byte by byte.
module tb_unidad_debug_recolector;

  localparam int LEN       = 32;
  localparam int NB_IF_ID  = 96;
  localparam int NB_ID_EX  = 160;
  localparam int NB_EX_MEM = 128;
  localparam int NB_MEM_WB = 96;
  localparam int CANT_REG  = 16;
  localparam int CANT_MEM  = 8;
  localparam int RD_LAT    = 1;
  localparam int NB_LAT    = NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
  localparam int WB        = LEN / 8;
  localparam int AWR       = $clog2(CANT_REG);
  localparam int AWM       = $clog2(CANT_MEM);
  localparam int FRAME_LEN = 1 + NB_LAT / 8 + (CANT_REG + CANT_MEM + 1) * WB;

  logic                 i_clk;
  logic                 i_rst;
  logic                 i_cmd_valid;
  logic [7:0]           i_cmd;
  logic                 o_cmd_ready;
  logic                 i_halt;
  logic [NB_IF_ID-1:0]  i_if_id;
  logic [NB_ID_EX-1:0]  i_id_ex;
  logic [NB_EX_MEM-1:0] i_ex_mem;
  logic [NB_MEM_WB-1:0] i_mem_wb;
  logic [LEN-1:0]       i_reg_reco;
  logic [LEN-1:0]       i_mem_reco;
  logic                 o_cpu_enable;
  logic                 o_debug_flag;
  logic [AWR-1:0]       o_addr_reg_reco;
  logic [AWM-1:0]       o_addr_memdatos_reco;
  logic [7:0]           o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;
  logic                 o_busy;
  logic [LEN-1:0]       o_cycle_count;

  unidad_debug_recolector #(
    .LEN(LEN), .NB_IF_ID(NB_IF_ID), .NB_ID_EX(NB_ID_EX), .NB_EX_MEM(NB_EX_MEM),
    .NB_MEM_WB(NB_MEM_WB), .CANT_REG(CANT_REG), .CANT_MEM(CANT_MEM), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .i_if_id(i_if_id),
    .i_id_ex(i_id_ex), .i_ex_mem(i_ex_mem), .i_mem_wb(i_mem_wb),
    .i_reg_reco(i_reg_reco), .i_mem_reco(i_mem_reco),
    .o_cpu_enable(o_cpu_enable), .o_debug_flag(o_debug_flag),
    .o_addr_reg_reco(o_addr_reg_reco), .o_addr_memdatos_reco(o_addr_memdatos_reco),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_cycle_count(o_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]     expQ[$];
  logic           expFlagQ[$];
  logic [7:0]     frameBytes[0:255];
  int             bytesSeen = 0;
  logic [LEN-1:0] modelCount = '0;
  logic [LEN-1:0] memBase = 32'h2000_0000;
  int             readyMode = 0;
  int             haltTarget = -1;
  bit             runActive = 0;
  int             enThisCmd = 0;
  logic           prevValid = 0;
  logic           prevReady = 0;
  logic [7:0]     prevData = '0;
  logic [AWR-1:0] histReg[0:3];
  logic [AWM-1:0] histMem[0:3];
  logic           histFlag[0:3];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic randomizeLatches();
    i_if_id  = {$urandom, $urandom, $urandom};
    i_id_ex  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    i_ex_mem = {$urandom, $urandom, $urandom, $urandom};
    i_mem_wb = {$urandom, $urandom, $urandom};
  endtask

  function automatic logic [LEN-1:0] regWord(input int i);
    return 32'h1000_0000 + LEN'(i);
  endfunction

  function automatic logic [LEN-1:0] memWord(input int i);
    return memBase + LEN'(i) * 32'h0000_0011;
  endfunction

  // Expected frame from the current latch inputs and the modelled count.
  task automatic buildFrame();
    logic [NB_LAT-1:0] lat;
    logic [LEN-1:0]    w;
    lat = {i_if_id, i_id_ex, i_ex_mem, i_mem_wb};
    expQ.push_back(8'hA5); expFlagQ.push_back(1'b0);
    for (int b = 0; b < NB_LAT / 8; b++) begin
      expQ.push_back(lat[NB_LAT-1-8*b -: 8]); expFlagQ.push_back(1'b0);
    end
    for (int i = 0; i < CANT_REG; i++) begin
      w = regWord(i);
      for (int b = 0; b < WB; b++) begin
        expQ.push_back(w[LEN-1-8*b -: 8]); expFlagQ.push_back(1'b1);
      end
    end
    for (int i = 0; i < CANT_MEM; i++) begin
      w = memWord(i);
      for (int b = 0; b < WB; b++) begin
        expQ.push_back(w[LEN-1-8*b -: 8]); expFlagQ.push_back(i != CANT_MEM - 1);
      end
    end
    w = modelCount;
    for (int b = 0; b < WB; b++) begin
      expQ.push_back(w[LEN-1-8*b -: 8]); expFlagQ.push_back(1'b0);
    end
  endtask

  // Read-port history: data seen in a cycle comes from the address (and
  // steering flag) presented RD_LAT cycles earlier; unsteered reads are junk.
  initial begin
    for (int k = 0; k < 4; k++) begin
      histReg[k] = '0; histMem[k] = '0; histFlag[k] = 1'b0;
    end
    forever begin
      @(negedge i_clk);
      for (int k = 3; k > 0; k--) begin
        histReg[k] = histReg[k-1]; histMem[k] = histMem[k-1]; histFlag[k] = histFlag[k-1];
      end
      histReg[0] = o_addr_reg_reco; histMem[0] = o_addr_memdatos_reco; histFlag[0] = o_debug_flag;
    end
  end

  // Per-cycle drivers: read data, sink ready pattern, CPU halt.
  initial begin
    i_reg_reco = '0; i_mem_reco = '0; i_tx_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_reg_reco = histFlag[RD_LAT-1] ? regWord(int'(histReg[RD_LAT-1])) : 32'hDEAD_BEEF;
      i_mem_reco = histFlag[RD_LAT-1] ? memWord(int'(histMem[RD_LAT-1])) : 32'hBAAD_F00D;
      case (readyMode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = ~i_tx_ready;
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (runActive && haltTarget >= 0 && enThisCmd >= haltTarget) i_halt = 1'b1;
    end
  end

  // Compare process: handshake rules, byte stream and steering flag.
  initial begin
    logic [7:0] e;
    logic       f;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        prevValid = 1'b0; prevReady = 1'b0;
      end else begin
        if (o_cpu_enable) enThisCmd++;
        checkOutput("enableGating", o_cpu_enable & i_halt, 0);
        checkOutput("busyVsReady", o_busy, !o_cmd_ready);
        if (prevValid && !prevReady) begin
          checkOutput("validHeld", o_tx_valid, 1);
          checkOutput("dataHeld", o_tx_data, prevData);
        end
        if (o_tx_valid && i_tx_ready) begin
          checkOutput("byteExpected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            f = expFlagQ.pop_front();
            checkOutput("txByte", o_tx_data, e);
            checkOutput("debugFlag", o_debug_flag, f);
          end
          if (bytesSeen < 256) frameBytes[bytesSeen] = o_tx_data;
          bytesSeen++;
          if (bytesSeen == 1) randomizeLatches();
        end
        prevValid = o_tx_valid; prevReady = i_tx_ready; prevData = o_tx_data;
      end
    end
  end

  task automatic doReset();
    i_rst = 1'b0;
    runActive = 0;
    i_halt = 1'b0;
    modelCount = '0;
    expQ.delete(); expFlagQ.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  // Issue one command; the model predicts enables, count and frame.
  task automatic applyStimulus(input logic [7:0] cmd, input int target, output int expEn);
    int waitCycles;
    bit accepted;
    expEn = 0;
    enThisCmd = 0;
    bytesSeen = 0;
    haltTarget = -1;
    runActive = 0;
    if (cmd == 8'h01) begin
      expEn = i_halt ? 0 : target;
      haltTarget = target;
      runActive = 1;
    end else if (cmd == 8'h02) begin
      expEn = i_halt ? 0 : 1;
    end
    modelCount = (LEN'(expEn) > ~modelCount) ? '1 : modelCount + LEN'(expEn);
    if (cmd inside {8'h01, 8'h02, 8'h03}) buildFrame();
    @(posedge i_clk);
    #2;
    i_cmd_valid = 1'b1;
    i_cmd = cmd;
    accepted = 0;
    waitCycles = 0;
    while (!accepted && waitCycles < 200) begin
      @(negedge i_clk);
      waitCycles++;
      if (o_cmd_ready) begin
        @(posedge i_clk);
        #2;
        accepted = 1;
      end
    end
    i_cmd_valid = 1'b0;
    checkOutput("cmdAccepted", accepted, 1);
  endtask

  task automatic waitFrameDone(input int expEn);
    int  cyc;
    bit  done;
    done = 0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge i_clk);
      cyc++;
      if (expQ.size() == 0 && !o_busy) done = 1;
    end
    runActive = 0;
    checkOutput("frameDone", done, 1);
    checkOutput("enableCycles", enThisCmd, expEn);
    checkOutput("cycleCount", o_cycle_count, modelCount);
    checkOutput("cmdReadyBack", o_cmd_ready, 1);
  endtask

  task automatic abortAt(input int byteNum, input bit expFlag);
    int cyc;
    cyc = 0;
    while (bytesSeen < byteNum && cyc < 5000) begin
      @(negedge i_clk);
      cyc++;
    end
    checkOutput("abortReached", bytesSeen >= byteNum, 1);
    checkOutput("flagBeforeAbort", o_debug_flag, expFlag);
    i_rst = 1'b0;
    #1;
    checkOutput("abortTxValid", o_tx_valid, 0);
    checkOutput("abortDebugFlag", o_debug_flag, 0);
    checkOutput("abortBusy", o_busy, 0);
    checkOutput("abortCycleCount", o_cycle_count, 0);
    doReset();
  endtask

  initial begin
    int expEn;
    int r;
    i_rst = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd = '0;
    i_halt = 1'b0;
    randomizeLatches();
    doReset();

    // Reset state
    checkOutput("resetCmdReady", o_cmd_ready, 1);
    checkOutput("resetBusy", o_busy, 0);
    checkOutput("resetTxValid", o_tx_valid, 0);
    checkOutput("resetTxData", o_tx_data, 0);
    checkOutput("resetCpuEnable", o_cpu_enable, 0);
    checkOutput("resetDebugFlag", o_debug_flag, 0);
    checkOutput("resetAddrReg", o_addr_reg_reco, 0);
    checkOutput("resetAddrMem", o_addr_memdatos_reco, 0);
    checkOutput("resetCycleCount", o_cycle_count, 0);

    // Plain DUMP with a always-ready sink, pinned by literal byte values
    readyMode = 0;
    applyStimulus(8'h03, 0, expEn);
    waitFrameDone(expEn);
    checkOutput("dumpLen", bytesSeen, 161);
    checkOutput("dumpLenModel", bytesSeen, FRAME_LEN);
    checkOutput("dumpHeader", frameBytes[0], 8'hA5);
    checkOutput("reg5Byte81", frameBytes[81], 8'h10);
    checkOutput("reg5Byte82", frameBytes[82], 8'h00);
    checkOutput("reg5Byte83", frameBytes[83], 8'h00);
    checkOutput("reg5Byte84", frameBytes[84], 8'h05);
    checkOutput("dumpCount", {frameBytes[157], frameBytes[158], frameBytes[159], frameBytes[160]}, 0);

    // Three STEPs with a random sink
    readyMode = 2;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(8'h02, 0, expEn);
      waitFrameDone(expEn);
    end
    checkOutput("stepCountByte", frameBytes[160], 8'h03);

    // RUN halting after 20 enabled cycles, then RUN while already halted
    doReset();
    readyMode = 0;
    applyStimulus(8'h01, 20, expEn);
    waitFrameDone(expEn);
    checkOutput("runCountByte", frameBytes[160], 8'h14);
    applyStimulus(8'h01, 20, expEn);
    waitFrameDone(expEn);
    checkOutput("haltedRunCountByte", frameBytes[160], 8'h14);

    // Toggling sink ready
    i_halt = 1'b0;
    readyMode = 1;
    memBase = $urandom;
    applyStimulus(8'h03, 0, expEn);
    waitFrameDone(expEn);
    checkOutput("toggleLen", bytesSeen, FRAME_LEN);

    // Unknown command byte is swallowed
    applyStimulus(8'h7F, 0, expEn);
    repeat (3) begin
      @(negedge i_clk);
      checkOutput("ignoredCmdIdle", o_busy, 0);
    end

    // Randomized command mix
    for (int it = 0; it < 6; it++) begin
      i_halt = 1'b0;
      memBase = $urandom;
      readyMode = $urandom_range(0, 2);
      r = $urandom_range(0, 2);
      if (r == 0)      applyStimulus(8'h01, $urandom_range(1, 30), expEn);
      else if (r == 1) applyStimulus(8'h02, 0, expEn);
      else             applyStimulus(8'h03, 0, expEn);
      waitFrameDone(expEn);
      checkOutput("randLen", bytesSeen, FRAME_LEN);
    end

    // Reset in the middle of a dump, then a clean restart
    i_halt = 1'b0;
    readyMode = 0;
    applyStimulus(8'h03, 0, expEn);
    abortAt(50, 1'b0);
    applyStimulus(8'h03, 0, expEn);
    abortAt(100, 1'b1);
    applyStimulus(8'h03, 0, expEn);
    waitFrameDone(expEn);
    checkOutput("restartHeader", frameBytes[0], 8'hA5);
    checkOutput("restartLen", bytesSeen, FRAME_LEN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
